// File: rtl/ibex_xif_pkg.sv
// Shared types and constants for the coprocessor result writeback path.
package ibex_xif_pkg;

    localparam int unsigned XifRegAddrW = 5;
    localparam int unsigned XifDataW    = 32;

    // One buffered coprocessor result: destination register and write data.
    typedef struct packed {
        logic [XifRegAddrW-1:0] rd;
        logic [XifDataW-1:0]    data;
    } xif_wb_entry_t;

endpackage

// File: rtl/ibex_xif_result_fifo.sv
// Small in-order result buffer with wrapping pointers and an occupancy counter.
// A push is also taken when full if the head is popped in the same cycle.
module ibex_xif_result_fifo
    import ibex_xif_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = xif_wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    entry_t          mem_q [Depth];
    logic            do_push, do_pop;

    // Status flags and qualified push/pop.
    always_comb begin
        full_o  = (cnt_q == CntW'(Depth));
        empty_o = (cnt_q == '0);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        rdata_o = mem_q[rptr_q];
    end

    // Pointer and occupancy state; pointers wrap modulo Depth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked by the counter.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ibex_xif_result_wb.sv
// Merges coprocessor results into the register-file write port behind the
// core's own writeback, tracks pending destination registers and flags
// protocol errors.
module ibex_xif_result_wb
    import ibex_xif_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned FifoDepth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   core_we_i,
    input  logic [XifRegAddrW-1:0] core_waddr_i,
    input  logic [DataWidth-1:0]   core_wdata_i,
    input  logic                   result_valid_i,
    output logic                   result_ready_o,
    input  logic                   result_we_i,
    input  logic [XifRegAddrW-1:0] result_rd_i,
    input  logic [DataWidth-1:0]   result_data_i,
    input  logic                   issue_valid_i,
    input  logic [XifRegAddrW-1:0] issue_rd_i,
    output logic                   rf_we_o,
    output logic [XifRegAddrW-1:0] rf_waddr_o,
    output logic [DataWidth-1:0]   rf_wdata_o,
    output logic [31:0]            rd_busy_o,
    output logic                   err_o
);

    typedef struct packed {
        logic [XifRegAddrW-1:0] rd;
        logic [DataWidth-1:0]   data;
    } wb_entry_t;

    // x0 never pends; RV32E has no x16-x31.
    localparam logic [31:0] BusyMask = RV32E ? 32'h0000_FFFE : 32'hFFFF_FFFE;

    logic      fifo_full, fifo_empty;
    logic      accept, push, pop;
    wb_entry_t push_entry, head;
    logic [31:0] busy_q, busy_d;
    logic      err_q, err_d;

    ibex_xif_result_fifo #(
        .Depth   (FifoDepth),
        .entry_t (wb_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Handshake, push/pop decisions and register-file arbitration (core first).
    always_comb begin
        result_ready_o  = !fifo_full && !rst_i;
        accept          = result_valid_i && result_ready_o;
        push            = accept && result_we_i && (result_rd_i != '0);
        push_entry.rd   = result_rd_i;
        push_entry.data = result_data_i;
        pop             = !rst_i && !core_we_i && !fifo_empty;
        rf_we_o         = 1'b0;
        rf_waddr_o      = '0;
        rf_wdata_o      = '0;
        if (!rst_i && core_we_i) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = core_waddr_i;
            rf_wdata_o = core_wdata_i;
        end else if (pop) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head.rd;
            rf_wdata_o = head.data;
        end
    end

    // Busy scoreboard update (set beats clear) and error detection.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head.rd] = 1'b0;
        end
        if (issue_valid_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d = busy_d & BusyMask;

        err_d = 1'b0;
        if (push && !busy_q[result_rd_i]) begin
            err_d = 1'b1;
        end
        // Re-issuing an rd whose result retires in this same cycle is legal.
        if (issue_valid_i && busy_q[issue_rd_i] && !(pop && (head.rd == issue_rd_i))) begin
            err_d = 1'b1;
        end
        if (RV32E && ((issue_valid_i && issue_rd_i[4]) || (accept && result_rd_i[4]))) begin
            err_d = 1'b1;
        end
    end

    // Scoreboard and error pulse registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign rd_busy_o = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ibex_xif_result_wb.sv
// Directed self-checking bench for ibex_xif_result_wb with default parameters.
module tb_ibex_xif_result_wb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_we_i;
    logic [4:0]  core_waddr_i;
    logic [31:0] core_wdata_i;
    logic        result_valid_i;
    logic        result_ready_o;
    logic        result_we_i;
    logic [4:0]  result_rd_i;
    logic [31:0] result_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] rd_busy_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    ibex_xif_result_wb #(
        .RV32E     (1'b0),
        .DataWidth (32),
        .FifoDepth (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .core_we_i      (core_we_i),
        .core_waddr_i   (core_waddr_i),
        .core_wdata_i   (core_wdata_i),
        .result_valid_i (result_valid_i),
        .result_ready_o (result_ready_o),
        .result_we_i    (result_we_i),
        .result_rd_i    (result_rd_i),
        .result_data_i  (result_data_i),
        .issue_valid_i  (issue_valid_i),
        .issue_rd_i     (issue_rd_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .rd_busy_o      (rd_busy_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge; inputs change only here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Sample point, half a cycle away from the active edge.
    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        core_we_i      = 1'b0;
        core_waddr_i   = '0;
        core_wdata_i   = '0;
        result_valid_i = 1'b0;
        result_we_i    = 1'b0;
        result_rd_i    = '0;
        result_data_i  = '0;
        issue_valid_i  = 1'b0;
        issue_rd_i     = '0;
    endtask

    task automatic drive_result(input logic [4:0] rd, input logic [31:0] data, input logic we);
        result_valid_i = 1'b1;
        result_we_i    = we;
        result_rd_i    = rd;
        result_data_i  = data;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_i = 1'b1;
        issue_rd_i    = rd;
        tick();
        issue_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i        = 1'b1;
        core_we_i    = 1'b1;
        core_waddr_i = 5'd2;
        sample();
        checks++;
        if (rf_we_o !== 1'b0 || result_ready_o !== 1'b0 || rd_busy_o !== 32'h0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: we=%b ready=%b busy=%h err=%b, want 0 0 00000000 0",
                     rf_we_o, result_ready_o, rd_busy_o, err_o);
        end
        tick();
        rst_i     = 1'b0;
        core_we_i = 1'b0;
        sample();
        checks++;
        if (result_ready_o !== 1'b1 || rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b we=%b, want 1 0", result_ready_o, rf_we_o);
        end
        tick();
    endtask

    task automatic test_idle_order();
        issue(5'd5);
        sample();
        checks++;
        if (rd_busy_o !== 32'h0000_0020) begin
            errors++;
            $display("FAIL idle_busy_set: busy=%h want 00000020", rd_busy_o);
        end
        tick();
        drive_result(5'd5, 32'hA5A5_0001, 1'b1);
        sample();
        checks++;
        if (result_ready_o !== 1'b1 || rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_accept: ready=%b we=%b want 1 0", result_ready_o, rf_we_o);
        end
        tick();
        result_valid_i = 1'b0;
        sample();
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'hA5A5_0001 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_write: we=%b addr=%0d data=%h err=%b want 1 5 a5a50001 0",
                     rf_we_o, rf_waddr_o, rf_wdata_o, err_o);
        end
        tick();
        sample();
        checks++;
        if (rd_busy_o !== 32'h0 || rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy_clear: busy=%h we=%b want 00000000 0", rd_busy_o, rf_we_o);
        end
        tick();
    endtask

    task automatic test_core_priority();
        issue(5'd3);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd7;
        core_wdata_i = 32'h0000_0777;
        drive_result(5'd3, 32'h3333_0003, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7 || rf_wdata_o !== 32'h0000_0777) begin
                errors++;
                $display("FAIL core_prio_c%0d: we=%b addr=%0d data=%h want 1 7 00000777",
                         i, rf_we_o, rf_waddr_o, rf_wdata_o);
            end
            tick();
            result_valid_i = 1'b0;
        end
        core_we_i = 1'b0;
        sample();
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd3 || rf_wdata_o !== 32'h3333_0003) begin
            errors++;
            $display("FAIL core_prio_drain: we=%b addr=%0d data=%h want 1 3 33330003",
                     rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
        sample();
        checks++;
        if (rf_we_o !== 1'b0 || rd_busy_o !== 32'h0) begin
            errors++;
            $display("FAIL core_prio_after: we=%b busy=%h want 0 00000000", rf_we_o, rd_busy_o);
        end
        tick();
    endtask

    task automatic test_full_boundary();
        issue(5'd10);
        issue(5'd11);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd1;
        core_wdata_i = 32'h1;
        drive_result(5'd10, 32'h0000_AAAA, 1'b1);
        sample();
        checks++;
        if (result_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_push0: ready=%b want 1", result_ready_o);
        end
        tick();
        drive_result(5'd11, 32'h0000_BBBB, 1'b1);
        sample();
        checks++;
        if (result_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_push1: ready=%b want 1", result_ready_o);
        end
        tick();
        result_valid_i = 1'b0;
        sample();
        checks++;
        if (result_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_low: ready=%b want 0", result_ready_o);
        end
        tick();
        core_we_i = 1'b0;
        sample();
        checks++;
        if (result_ready_o !== 1'b0 || rf_we_o !== 1'b1 || rf_waddr_o !== 5'd10 || rf_wdata_o !== 32'h0000_AAAA) begin
            errors++;
            $display("FAIL full_pop0: ready=%b we=%b addr=%0d data=%h want 0 1 10 0000aaaa",
                     result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
        sample();
        checks++;
        if (result_ready_o !== 1'b1 || rf_we_o !== 1'b1 || rf_waddr_o !== 5'd11 || rf_wdata_o !== 32'h0000_BBBB) begin
            errors++;
            $display("FAIL full_pop1: ready=%b we=%b addr=%0d data=%h want 1 1 11 0000bbbb",
                     result_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
        sample();
        checks++;
        if (rf_we_o !== 1'b0 || rd_busy_o !== 32'h0) begin
            errors++;
            $display("FAIL full_drained: we=%b busy=%h want 0 00000000", rf_we_o, rd_busy_o);
        end
        tick();
    endtask

    task automatic test_set_clear();
        issue(5'd9);
        drive_result(5'd9, 32'h9999_0009, 1'b1);
        tick();
        result_valid_i = 1'b0;
        issue_valid_i  = 1'b1;
        issue_rd_i     = 5'd9;
        sample();
        checks++;
        if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd9) begin
            errors++;
            $display("FAIL setclr_pop: we=%b addr=%0d want 1 9", rf_we_o, rf_waddr_o);
        end
        tick();
        issue_valid_i = 1'b0;
        sample();
        checks++;
        if (rd_busy_o !== 32'h0000_0200) begin
            errors++;
            $display("FAIL setclr_busy: busy=%h want 00000200", rd_busy_o);
        end
        // Retire the re-issued x9 so later scenarios start clean.
        drive_result(5'd9, 32'h9999_0019, 1'b1);
        tick();
        result_valid_i = 1'b0;
        tick();
        sample();
        checks++;
        if (rd_busy_o !== 32'h0) begin
            errors++;
            $display("FAIL setclr_retire: busy=%h want 00000000", rd_busy_o);
        end
        tick();
    endtask

    task automatic test_errors_discard();
        issue(5'd4);
        drive_result(5'd12, 32'hC0DE_000C, 1'b1);
        sample();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_before: err=%b want 0", err_o);
        end
        tick();
        drive_result(5'd4, 32'hDEAD_0004, 1'b0);
        sample();
        checks++;
        if (err_o !== 1'b1 || rf_we_o !== 1'b1 || rf_waddr_o !== 5'd12 || rf_wdata_o !== 32'hC0DE_000C) begin
            errors++;
            $display("FAIL err_pulse_write: err=%b we=%b addr=%0d data=%h want 1 1 12 c0de000c",
                     err_o, rf_we_o, rf_waddr_o, rf_wdata_o);
        end
        tick();
        result_valid_i = 1'b0;
        sample();
        checks++;
        if (err_o !== 1'b0 || rf_we_o !== 1'b0 || rd_busy_o !== 32'h0000_0010) begin
            errors++;
            $display("FAIL err_discard: err=%b we=%b busy=%h want 0 0 00000010",
                     err_o, rf_we_o, rd_busy_o);
        end
        tick();
        sample();
        checks++;
        if (rf_we_o !== 1'b0 || rd_busy_o !== 32'h0000_0010) begin
            errors++;
            $display("FAIL err_discard_later: we=%b busy=%h want 0 00000010", rf_we_o, rd_busy_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        issue(5'd13);
        issue(5'd14);
        core_we_i    = 1'b1;
        core_waddr_i = 5'd1;
        drive_result(5'd13, 32'h1313_1313, 1'b1);
        tick();
        drive_result(5'd14, 32'h1414_1414, 1'b1);
        tick();
        result_valid_i = 1'b0;
        sample();
        checks++;
        if (result_ready_o !== 1'b0 || rd_busy_o !== 32'h0000_6010) begin
            errors++;
            $display("FAIL rst_mid_pre: ready=%b busy=%h want 0 00006010", result_ready_o, rd_busy_o);
        end
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || rd_busy_o !== 32'h0 || result_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_now: we=%b busy=%h ready=%b want 0 00000000 0",
                     rf_we_o, rd_busy_o, result_ready_o);
        end
        core_we_i = 1'b0;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            checks++;
            if (rf_we_o !== 1'b0 || rd_busy_o !== 32'h0) begin
                errors++;
                $display("FAIL rst_mid_after_c%0d: we=%b busy=%h want 0 00000000",
                         i, rf_we_o, rd_busy_o);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_idle_order();
        test_core_priority();
        test_full_boundary();
        test_set_clear();
        test_errors_discard();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
